ram_arbiter: RTL

//   Shares the single-ported RAM between the instruction-fetch requester and the

---
 rtl/ram_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and data memory.
// Data wins by default; a starvation counter forces an instruction grant.
module ram_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SERV_I, SERV_D} state_t;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic              op_q, op_d;     // 1 = write
    logic              d_req, force_i;

    assign d_req   = dREN | dWEN;
    assign force_i = iREN && (starve_q == CNT_MAX);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        store_d  = store_q;
        op_d     = op_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (d_req && !force_i) begin
                    state_d = SERV_D;
                    addr_d  = daddr;
                    store_d = dstore;
                    op_d    = dWEN;
                end else if (iREN) begin
                    state_d = SERV_I;
                    addr_d  = iaddr;
                    store_d = '0;
                    op_d    = 1'b0;
                end
            end
            SERV_I, SERV_D: if (ramready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!iREN)
            starve_d = '0;
        else if (state_q == IDLE && state_d == SERV_I)
            starve_d = '0;
        else if (state_q != SERV_I && starve_q != CNT_MAX)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            addr_q   <= '0;
            store_q  <= '0;
            op_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            op_q     <= op_d;
        end
    end

    // RAM command comes only from the latched request, gated off in IDLE.
    assign busy     = (state_q != IDLE);
    assign ramREN   = (state_q == SERV_I) || (state_q == SERV_D && !op_q);
    assign ramWEN   = (state_q == SERV_D) && op_q;
    assign ramaddr  = busy ? addr_q : '0;
    assign ramstore = ramWEN ? store_q : '0;

    assign iwait = iREN && !(state_q == SERV_I && ramready);
    assign dwait = d_req && !(state_q == SERV_D && ramready);
    assign iload = (state_q == SERV_I) ? ramload : '0;
    assign dload = (state_q == SERV_D && !op_q) ? ramload : '0;

endmodule
